irq_ack_controller: RTL and testbench
=====================================

Name: irq_ack_controller

Overview:
CPU-side responder for the 4-input interrupt priority encoder. It consumes the encoder's IRQ/y pair and raises a request to the CPU. It runs the acknowledge / end-of-interrupt handshake and returns a one-cycle one-hot clear pulse to the interrupt sources for the serviced vector. It also tracks the in-service vector and aborts requests the CPU never acknowledges.

Parameters:
NUM_IRQ, 4, number of interrupt lines (vector width = 2; only 4 is supported).
ACK_TIMEOUT, 16, number of PENDING cycles without cpu_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
irq_in  in  1  encoder IRQ output: an interrupt is active
y_in  in  2  encoder vector; 0 is highest priority, 3 is lowest
irq_mask  in  4  per-vector mask; 1 = ignore that vector
cpu_ack  in  1  CPU acknowledges the current request
cpu_eoi  in  1  CPU signals end of interrupt service
cpu_irq  out  1  interrupt request to the CPU
cpu_vector  out  2  latched vector presented with cpu_irq
int_clear  out  4  one-hot, single-cycle clear pulse to the source
in_service  out  4  one-hot in-service vector
timeout_err  out  1  single-cycle pulse when a request is aborted

Behaviour:
- Reset (async, immediate): state=IDLE. cpu_irq=0, cpu_vector=0, int_clear=0, in_service=0, timeout_err=0, timeout counter=0. Reset mid-handshake discards the latched vector and the in-service bit.
- All outputs are registered.
- States: IDLE, PENDING, ACTIVE.
- IDLE:
  - At an edge with irq_in=1 and irq_mask[y_in]=0: latch cpu_vector=y_in, clear the counter, go to PENDING.
  - cpu_irq goes to 1 in the same edge, so there is 1 cycle of latency from input to request.
  - A masked vector is ignored and the block stays in IDLE. cpu_ack and cpu_eoi are ignored.
- PENDING:
  - cpu_irq=1; cpu_vector is held and cannot be changed by y_in (no preemption).
  - At an edge with cpu_ack=1: go to ACTIVE, cpu_irq=0, int_clear[cpu_vector]=1 for exactly one cycle, in_service[cpu_vector]=1.
  - If cpu_ack=0: the counter increments. When ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT-1 with no ack, go to IDLE, cpu_irq=0, timeout_err=1 for one cycle, and issue no int_clear.
  - If cpu_ack arrives in the same cycle as the terminal count, ack wins and there is no timeout_err.
  - The counter saturates and never wraps.
  - cpu_eoi is ignored in this state.
- ACTIVE:
  - cpu_irq=0 and in_service is held; irq_in and cpu_ack are ignored.
  - At an edge with cpu_eoi=1: in_service=0, go to IDLE. irq_in is sampled from that IDLE cycle onward.
  - The minimum gap from eoi to the next cpu_irq is 2 edges.
- int_clear is 0 in every cycle except the one following the ack edge.
- The in_service popcount is always 0 or 1.
- Changing irq_mask while in PENDING or ACTIVE has no effect on the in-flight vector.

Test Plan:
- Reset behaviour: hold rst=1 with irq_in=1, y_in=2 -> all outputs 0. Release rst -> cpu_irq=1 and cpu_vector=2'b10 one edge later.
- Full handshake:
  - Stimulus: irq_in=1, y_in=1; ack after 3 cycles; eoi 4 cycles later.
  - Response: int_clear=4'b0010 for exactly 1 cycle and in_service=4'b0010 until eoi, then 0.
- No preemption: in PENDING with vector 3, change y_in to 0 -> cpu_vector stays 2'b11. After eoi, the next request carries vector 0.
- Mask: irq_mask=4'b0100, irq_in=1, y_in=2 for 10 cycles -> cpu_irq stays 0. Clearing the mask -> cpu_irq=1 one edge later.
- Timeout: ACK_TIMEOUT=16, no ack -> cpu_irq drops after 16 PENDING cycles, timeout_err pulses once, int_clear=0 throughout.
- Simultaneous events:
  - Ack asserted exactly on the terminal-count cycle -> ACTIVE, no timeout_err.
  - Async rst asserted mid-ACTIVE -> in_service=0 immediately.

Source files
------------

// File: rtl/irq_ack_controller.sv
// irq_ack_controller: CPU-side ack/EOI handshake for a 4-input priority encoder.
// Latches the vector, raises cpu_irq, pulses int_clear on ack and aborts unacknowledged requests.
module irq_ack_controller #(
    parameter int NUM_IRQ     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       irq_in,
    input  logic [$clog2(NUM_IRQ)-1:0] y_in,
    input  logic [NUM_IRQ-1:0]         irq_mask,
    input  logic                       cpu_ack,
    input  logic                       cpu_eoi,
    output logic                       cpu_irq,
    output logic [$clog2(NUM_IRQ)-1:0] cpu_vector,
    output logic [NUM_IRQ-1:0]         int_clear,
    output logic [NUM_IRQ-1:0]         in_service,
    output logic                       timeout_err
);
    localparam int VW = $clog2(NUM_IRQ);
    localparam int CW = ACK_TIMEOUT > 2 ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 irq_q, irq_d, to_q, to_d;
    logic [VW-1:0]        vec_q, vec_d;
    logic [NUM_IRQ-1:0]   clr_q, clr_d, ins_q, ins_d, vec_oh;

    assign vec_oh = NUM_IRQ'(1) << vec_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        vec_d   = vec_q;
        clr_d   = '0;
        ins_d   = ins_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: if (irq_in && !irq_mask[y_in]) begin
                state_d = PENDING;
                vec_d   = y_in;
                cnt_d   = '0;
                irq_d   = 1'b1;
            end
            PENDING: if (cpu_ack) begin
                state_d = ACTIVE;
                clr_d   = vec_oh;
                ins_d   = vec_oh;
            end else if (ACK_TIMEOUT != 0 && cnt_q == TERM) begin
                state_d = IDLE;
                to_d    = 1'b1;
            end else begin
                irq_d = 1'b1;
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
            end
            ACTIVE: if (cpu_eoi) begin
                state_d = IDLE;
                ins_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            clr_q   <= '0;
            ins_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            clr_q   <= clr_d;
            ins_q   <= ins_d;
            to_q    <= to_d;
        end
    end

    assign cpu_irq     = irq_q;
    assign cpu_vector  = vec_q;
    assign int_clear   = clr_q;
    assign in_service  = ins_q;
    assign timeout_err = to_q;
endmodule

// File: tb/tb_irq_ack_controller.sv
// tb_irq_ack_controller: directed self-checking bench for irq_ack_controller.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_irq_ack_controller;
    logic       clk = 1'b0;
    logic       rst, irq_in, cpu_ack, cpu_eoi;
    logic [1:0] y_in, cpu_vector;
    logic [3:0] irq_mask, int_clear, in_service;
    logic       cpu_irq, timeout_err;
    int         n_chk = 0;
    int         n_fail = 0;

    irq_ack_controller #(.NUM_IRQ(4), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .y_in(y_in), .irq_mask(irq_mask),
        .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .cpu_irq(cpu_irq), .cpu_vector(cpu_vector),
        .int_clear(int_clear), .in_service(in_service), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic irq, input logic [1:0] vec,
                           input logic [3:0] clr, input logic [3:0] ins, input logic to);
        chk({tag, ".cpu_irq"}, cpu_irq, irq);
        chk({tag, ".cpu_vector"}, cpu_vector, vec);
        chk({tag, ".int_clear"}, int_clear, clr);
        chk({tag, ".in_service"}, in_service, ins);
        chk({tag, ".timeout_err"}, timeout_err, to);
    endtask

    initial begin
        rst = 1'b1; irq_in = 1'b1; y_in = 2'd2; irq_mask = 4'b0000; cpu_ack = 1'b0; cpu_eoi = 1'b0;
        step(2);
        chk_all("reset", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        step(1);
        chk_all("post_reset_req", 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
        irq_in = 1'b0; cpu_ack = 1'b1;
        step(1);
        chk_all("post_reset_ack", 1'b0, 2'd2, 4'b0100, 4'b0100, 1'b0);
        cpu_ack = 1'b0; cpu_eoi = 1'b1;
        step(1);
        chk_all("post_reset_eoi", 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0);
        cpu_eoi = 1'b0;

        // full handshake on vector 1
        irq_in = 1'b1; y_in = 2'd1;
        step(1);
        chk_all("hs_req", 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
        irq_in = 1'b0;
        step(2);
        chk_all("hs_wait", 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0);
        cpu_ack = 1'b1;
        step(1);
        chk_all("hs_ack", 1'b0, 2'd1, 4'b0010, 4'b0010, 1'b0);
        cpu_ack = 1'b0;
        step(1);
        chk_all("hs_clr_once", 1'b0, 2'd1, 4'b0000, 4'b0010, 1'b0);
        step(2);
        chk("hs_ins_held", in_service, 4'b0010);
        cpu_eoi = 1'b1;
        step(1);
        chk_all("hs_eoi", 1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0);
        cpu_eoi = 1'b0;

        // no preemption: vector 3 held while y_in moves to 0
        irq_in = 1'b1; y_in = 2'd3;
        step(1);
        chk_all("np_req", 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0);
        y_in = 2'd0;
        step(2);
        chk_all("np_held", 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0);
        cpu_ack = 1'b1;
        step(1);
        chk_all("np_ack", 1'b0, 2'd3, 4'b1000, 4'b1000, 1'b0);
        cpu_ack = 1'b0;
        step(1);
        chk("np_active_no_irq", cpu_irq, 1'b0);
        cpu_eoi = 1'b1;
        step(1);
        chk_all("np_eoi_gap", 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0);
        cpu_eoi = 1'b0;
        step(1);
        chk_all("np_next_req", 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
        irq_in = 1'b0; cpu_ack = 1'b1;
        step(1);
        cpu_ack = 1'b0; cpu_eoi = 1'b1;
        step(1);
        cpu_eoi = 1'b0;
        chk("np_done", in_service, 4'b0000);

        // masked vector ignored
        irq_mask = 4'b0100; irq_in = 1'b1; y_in = 2'd2;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("mask_idle%0d", i), cpu_irq, 1'b0);
        end
        irq_mask = 4'b0000;
        step(1);
        chk_all("mask_clear", 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);

        // timeout on that request; re-masking mid-flight has no effect
        irq_in = 1'b0; irq_mask = 4'b0100;
        for (int i = 1; i <= 15; i++) begin
            step(1);
            chk_all($sformatf("to_pend%0d", i), 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
        end
        step(1);
        chk_all("to_abort", 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b1);
        step(1);
        chk_all("to_pulse_once", 1'b0, 2'd2, 4'b0000, 4'b0000, 1'b0);
        irq_mask = 4'b0000;

        // ack on terminal-count cycle wins over timeout
        irq_in = 1'b1; y_in = 2'd1;
        step(1);
        irq_in = 1'b0;
        step(15);
        chk("tc_still_pending", cpu_irq, 1'b1);
        cpu_ack = 1'b1;
        step(1);
        chk_all("tc_ack_wins", 1'b0, 2'd1, 4'b0010, 4'b0010, 1'b0);
        cpu_ack = 1'b0;
        step(1);
        chk_all("tc_after", 1'b0, 2'd1, 4'b0000, 4'b0010, 1'b0);

        // asynchronous reset while ACTIVE
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
        step(1);
        rst = 1'b0;
        step(2);
        chk_all("after_rst_idle", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
